// File: rtl/shift_rotate_pkg.sv
// rtl/shift_rotate_pkg.sv - opcodes and FSM states for the sequential shift/rotate unit
package shift_rotate_pkg;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;
    localparam logic [2:0] OP_ASL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_ASL;
    endfunction

endpackage

// File: rtl/shift_rotate_step.sv
// rtl/shift_rotate_step.sv - combinational shift/rotate of one word by 0..STEP bits
module shift_rotate_step
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    input  logic [2:0]       opcode,
    input  logic [AMT_W-1:0] n,
    output logic [WIDTH-1:0] word_out,
    output logic             carry,
    output logic             sign_changed
);

    logic [WIDTH-1:0] w;
    logic             c;
    logic             sc;
    logic             msb;

    // Applied as n single-bit moves so carry and sign change track every intermediate bit.
    always_comb begin
        w   = word;
        c   = 1'b0;
        sc  = 1'b0;
        msb = word[WIDTH-1];
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < n) begin
                case (opcode)
                    OP_LSL, OP_ASL: begin
                        c = w[WIDTH-1];
                        w = {w[WIDTH-2:0], 1'b0};
                    end
                    OP_LSR: begin
                        c = w[0];
                        w = {1'b0, w[WIDTH-1:1]};
                    end
                    OP_ROL: begin
                        c = w[WIDTH-1];
                        w = {w[WIDTH-2:0], w[WIDTH-1]};
                    end
                    OP_ROR: begin
                        c = w[0];
                        w = {w[0], w[WIDTH-1:1]};
                    end
                    OP_ASR: begin
                        c = w[0];
                        w = {w[WIDTH-1], w[WIDTH-1:1]};
                    end
                    default: ;
                endcase
                if (w[WIDTH-1] != msb) sc = 1'b1;
                msb = w[WIDTH-1];
            end
        end
        word_out     = w;
        carry        = c;
        sign_changed = sc;
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// rtl/shift_rotate_seq.sv - multi-cycle shift/rotate unit with valid/ready request and result
module shift_rotate_seq
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       opcode,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    state_t           state;
    logic [2:0]       opcode_q;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] amt_c;
    logic [AMT_W-1:0] step_n;
    logic [WIDTH-1:0] step_word;
    logic             step_carry;
    logic             step_sc;

    // Amounts beyond WIDTH-1 only exist for non-power-of-two widths; clamp them.
    generate
        if ((1 << AMT_W) == WIDTH) begin : g_no_clamp
            assign amt_c = amt;
        end else begin : g_clamp
            assign amt_c = (int'(amt) > WIDTH - 1) ? AMT_W'(WIDTH - 1) : amt;
        end
    endgenerate

    assign step_n = (remaining > AMT_W'(STEP)) ? AMT_W'(STEP) : remaining;

    shift_rotate_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .word         (result),
        .opcode       (opcode_q),
        .n            (step_n),
        .word_out     (step_word),
        .carry        (step_carry),
        .sign_changed (step_sc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            opcode_q  <= OP_LSL;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        result    <= a;
                        opcode_q  <= opcode;
                        remaining <= amt_c;
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        in_ready  <= 1'b0;
                        if (!op_legal(opcode)) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else if (amt_c == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    result    <= step_word;
                    carry     <= step_carry;
                    if (opcode_q == OP_ASL && step_sc) ovf <= 1'b1;
                    remaining <= remaining - step_n;
                    if (remaining == step_n) state <= ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle raises out_valid; it then waits for the handshake.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb/tb_shift_rotate_seq.sv - randomized self-checking bench for shift_rotate_seq (STEP=1 and STEP=3)
module tb_shift_rotate_seq;

    logic       clk;
    logic       rst;
    logic       iv   [2];
    logic       ir   [2];
    logic       ov   [2];
    logic       ordy [2];
    logic       cy   [2];
    logic       ovf  [2];
    logic       er   [2];
    logic [7:0] av   [2];
    logic [7:0] res  [2];
    logic [2:0] op   [2];
    logic [2:0] amt  [2];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shift_rotate_seq #(.WIDTH(8), .AMT_W(3), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]),
        .opcode(op[0]), .amt(amt[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .result(res[0]), .carry(cy[0]), .ovf(ovf[0]), .err(er[0])
    );

    shift_rotate_seq #(.WIDTH(8), .AMT_W(3), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]),
        .opcode(op[1]), .amt(amt[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .result(res[1]), .carry(cy[1]), .ovf(ovf[1]), .err(er[1])
    );

    // Whole-operation reference: plain shifts on the full amount, rotates via a doubled word.
    task automatic ref_model(input logic [7:0] x, input logic [2:0] o, input logic [2:0] k3,
                             output logic [7:0] r, output logic c, output logic v, output logic e);
        int          k;
        logic [15:0] d;
        logic [7:0]  top;
        k = int'(k3);
        c = 1'b0; v = 1'b0; e = 1'b0;
        case (o)
            3'd0, 3'd5: begin
                r = x << k;
                if (k > 0) c = x[8-k];
                if (o == 3'd5 && k > 0) begin
                    top = x >> (7 - k);
                    v = !(top == 8'h00 || top == (8'hFF >> (7 - k)));
                end
            end
            3'd1: begin r = x >> k; if (k > 0) c = x[k-1]; end
            3'd2: begin d = {x, x} << k; r = d[15:8]; if (k > 0) c = r[0]; end
            3'd3: begin d = {x, x} >> k; r = d[7:0]; if (k > 0) c = r[7]; end
            3'd4: begin r = $signed(x) >>> k; if (k > 0) c = x[k-1]; end
            default: begin r = x; e = 1'b1; end
        endcase
    endtask

    task automatic run_op(input int s, input logic [7:0] x, input logic [2:0] o, input logic [2:0] k,
                          input int hold, input string name);
        logic [7:0] er_r;
        logic       ec, ev, ee;
        int         lat, exp_lat, stp;
        logic [10:0] snap;
        stp = (s == 0) ? 1 : 3;
        ref_model(x, o, k, er_r, ec, ev, ee);
        exp_lat = ee ? 1 : 1 + (int'(k) + stp - 1) / stp;
        @(negedge clk);
        tests++;
        if (ir[s] !== 1'b1) begin fails++; $display("FAIL %s in_ready_idle: got %b want 1", name, ir[s]); end
        iv[s] = 1'b1; av[s] = x; op[s] = o; amt[s] = k; ordy[s] = 1'b0;
        @(negedge clk);
        // Keep in_valid high with junk operands while busy: it must be ignored.
        av[s] = 8'($urandom); op[s] = 3'($urandom); amt[s] = 3'($urandom);
        lat = 0;
        while (!ov[s] && lat < 64) begin
            tests++;
            if (ir[s] !== 1'b0) begin fails++; $display("FAIL %s in_ready_busy: got %b want 0", name, ir[s]); end
            @(negedge clk);
            lat++;
        end
        iv[s] = 1'b0;
        tests++;
        if (lat !== exp_lat) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
        tests++;
        if ({res[s], cy[s], ovf[s], er[s]} !== {er_r, ec, ev, ee}) begin
            fails++;
            $display("FAIL %s result: got r=%b c=%b v=%b e=%b want r=%b c=%b v=%b e=%b",
                     name, res[s], cy[s], ovf[s], er[s], er_r, ec, ev, ee);
        end
        snap = {res[s], cy[s], ovf[s], er[s]};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            tests++;
            if ({ov[s], ir[s], res[s], cy[s], ovf[s], er[s]} !== {1'b1, 1'b0, snap}) begin
                fails++;
                $display("FAIL %s hold%0d: got ov=%b ir=%b out=%b want ov=1 ir=0 out=%b",
                         name, i, ov[s], ir[s], {res[s], cy[s], ovf[s], er[s]}, snap);
            end
        end
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        tests++;
        if (ov[s] !== 1'b0 || ir[s] !== 1'b1) begin
            fails++; $display("FAIL %s handshake: got ov=%b ir=%b want ov=0 ir=1", name, ov[s], ir[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            tests++;
            if ({ir[s], ov[s], res[s], cy[s], ovf[s], er[s]} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
                fails++;
                $display("FAIL reset%0d: got ir=%b ov=%b r=%h c=%b v=%b e=%b want ir=1 ov=0 r=00 c=0 v=0 e=0",
                         s, ir[s], ov[s], res[s], cy[s], ovf[s], er[s]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        run_op(0, 8'b10110101, 3'b000, 3'd3, 0, "lsl3");
        run_op(0, 8'b10110101, 3'b001, 3'd3, 0, "lsr3");
        run_op(0, 8'b10110101, 3'b010, 3'd3, 0, "rol3");
        run_op(0, 8'b10110101, 3'b011, 3'd3, 0, "ror3");
        run_op(0, 8'b10110101, 3'b100, 3'd3, 0, "asr3");
        run_op(0, 8'b10110101, 3'b101, 3'd2, 0, "asl2");
        run_op(0, 8'b10110101, 3'b001, 3'd0, 0, "lsr0");
        run_op(0, 8'b10110101, 3'b110, 3'd5, 0, "illegal110");
        run_op(0, 8'b10110101, 3'b111, 3'd1, 0, "illegal111");
    endtask

    task automatic test_backpressure();
        run_op(0, 8'b10110101, 3'b000, 3'd3, 5, "bp_lsl");
        run_op(1, 8'b01001110, 3'b101, 3'd7, 5, "bp_asl_s3");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iv[0] = 1'b1; av[0] = 8'b10110101; op[0] = 3'b010; amt[0] = 3'd7;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            fails++; $display("FAIL reset_mid_async: got ir=%b ov=%b want ir=1 ov=0", ir[0], ov[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            fails++; $display("FAIL reset_mid_after: got ir=%b ov=%b want ir=1 ov=0", ir[0], ov[0]);
        end
        run_op(0, 8'b10110101, 3'b010, 3'd7, 0, "rol7_after_rst");
    endtask

    task automatic test_step3();
        run_op(1, 8'b10110101, 3'b011, 3'd7, 0, "s3_ror7");
        run_op(1, 8'b10110101, 3'b000, 3'd3, 0, "s3_lsl3");
        run_op(1, 8'b10110101, 3'b101, 3'd4, 0, "s3_asl4");
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            run_op(i % 2, 8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom), $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; ordy[s] = 1'b0; av[s] = '0; op[s] = '0; amt[s] = '0;
        end
        rst = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_step3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
